axis_fifo_scheduler: RTL and testbench

AXIS_FIFO_SCHEDULER -- requirements
Module: axis_fifo_scheduler

---
 rtl/axis_fifo_scheduler.sv | 175 +++++++++++++++++
 tb/tb_axis_fifo_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_fifo_scheduler: round-robin packet scheduler over NUM_CH AXIS FIFOs.
// Optional beat watchdog enabled by defining SCHED_WATCHDOG_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module axis_fifo_scheduler #(
  parameter int NUM_CH    = 14,
  parameter int MAX_BEATS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_en,
  input  logic [NUM_CH-1:0] src_tvalid,
  input  logic [NUM_CH-1:0] src_tlast,
  input  logic              dst_tready,
  output logic [7:0]        bus_sel,
  output logic              busy,
  output logic              pkt_done
`ifdef SCHED_WATCHDOG_EN
  , output logic            wdog_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  bus_sel_n;
  logic        pkt_done_n;
  logic [6:0]  rr_ptr;
  logic [6:0]  rr_ptr_n;
  logic [15:0] beat_cnt;
  logic [15:0] beat_cnt_n;

  logic [6:0]  grant;
  logic [6:0]  next_ptr;
  logic        sel_valid;
  logic        sel_last;
  logic        beat_acc;

  logic        arb_found;
  logic [6:0]  arb_idx;
  logic [7:0]  arb_dist;
  logic [7:0]  arb_best;

  // The low 7 bits of the registered select code are the granted channel.
  assign grant    = bus_sel[6:0];
  assign next_ptr = (grant == 7'(NUM_CH - 1)) ? 7'd0 : grant + 7'd1;
  assign busy     = (state == XFER);
  assign beat_acc = sel_valid & dst_tready;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == 7'(i)) begin
        sel_valid = src_tvalid[i];
        sel_last  = src_tlast[i];
      end
    end
  end

  // Round-robin pick: smallest forward distance from rr_ptr among valid channels.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 7'd0;
    arb_dist  = 8'd0;
    arb_best  = 8'hFF;
    for (int j = 0; j < NUM_CH; j++) begin
      if (src_tvalid[j]) begin
        if (7'(j) >= rr_ptr)
          arb_dist = {1'b0, 7'(j)} - {1'b0, rr_ptr};
        else
          arb_dist = {1'b0, 7'(j)} + 8'(NUM_CH) - {1'b0, rr_ptr};
        if (arb_dist < arb_best) begin
          arb_best  = arb_dist;
          arb_idx   = 7'(j);
          arb_found = 1'b1;
        end
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  logic wdog_err_n;
  logic limit_hit;

  assign limit_hit = ((beat_cnt + 16'd1) == 16'(MAX_BEATS));
`endif

  always_comb begin
    state_n    = state;
    bus_sel_n  = bus_sel;
    pkt_done_n = 1'b0;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
`ifdef SCHED_WATCHDOG_EN
    wdog_err_n = wdog_err;
`endif
    case (state)
      IDLE: begin
        bus_sel_n = 8'd0;
        if (sched_en && (|src_tvalid))
          state_n = ARB;
      end
      ARB: begin
        if (arb_found) begin
          bus_sel_n = {1'b1, arb_idx};
          state_n   = XFER;
        end else begin
          bus_sel_n = 8'd0;
          state_n   = IDLE;
        end
      end
      XFER: begin
        if (beat_acc) begin
          if (sel_last) begin
            state_n    = IDLE;
            bus_sel_n  = 8'd0;
            pkt_done_n = 1'b1;
            beat_cnt_n = 16'd0;
            rr_ptr_n   = next_ptr;
          end else begin
            beat_cnt_n = beat_cnt + 16'd1;
`ifdef SCHED_WATCHDOG_EN
            // A beat that reaches the limit without tlast forces the exit.
            if (limit_hit) begin
              state_n    = IDLE;
              bus_sel_n  = 8'd0;
              beat_cnt_n = 16'd0;
              rr_ptr_n   = next_ptr;
              wdog_err_n = 1'b1;
            end
`endif
          end
        end
      end
      default: begin
        state_n   = IDLE;
        bus_sel_n = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus_sel  <= 8'd0;
      pkt_done <= 1'b0;
      rr_ptr   <= 7'd0;
      beat_cnt <= 16'd0;
    end else begin
      state    <= state_n;
      bus_sel  <= bus_sel_n;
      pkt_done <= pkt_done_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wdog_err <= 1'b0;
    else
      wdog_err <= wdog_err_n;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_fifo_scheduler: randomized self-checking bench with a transaction
// level round-robin reference model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_axis_fifo_scheduler;

  localparam int NUM_CH    = 14;
  localparam int MAX_BEATS = 4;

  logic              clk;
  logic              rst_n;
  logic              sched_en;
  logic [NUM_CH-1:0] src_tvalid;
  logic [NUM_CH-1:0] src_tlast;
  logic              dst_tready;
  logic [7:0]        bus_sel;
  logic              busy;
  logic              pkt_done;
`ifdef SCHED_WATCHDOG_EN
  logic              wdog_err;
`endif

  int n_cmp;
  int n_err;
  int m_rr;

  axis_fifo_scheduler #(
    .NUM_CH    (NUM_CH),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sched_en   (sched_en),
    .src_tvalid (src_tvalid),
    .src_tlast  (src_tlast),
    .dst_tready (dst_tready),
    .bus_sel    (bus_sel),
    .busy       (busy),
    .pkt_done   (pkt_done)
`ifdef SCHED_WATCHDOG_EN
    , .wdog_err (wdog_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // First requesting channel at or after the model pointer, wrapping.
  function automatic int model_pick(input logic [NUM_CH-1:0] v);
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise requests in IDLE; ARB follows, grant is visible two edges later.
  task automatic request(input logic [NUM_CH-1:0] mask, output int g);
    sched_en   = 1'b1;
    src_tvalid = mask;
    src_tlast  = '0;
    dst_tready = 1'b0;
    g = model_pick(mask);
    step();
    check("arb_busy", busy, 0);
    check("arb_sel", bus_sel, 0);
    check("arb_pkt_done", pkt_done, 0);
    step();
    check("grant_sel", bus_sel, 128 + g);
    check("grant_busy", busy, 1);
  endtask

  // Stream one packet of nbeats on channel g; tlast on the final accepted beat.
  task automatic stream(input int g, input int nbeats, input int stalls,
                        input bit rnd, input bit drop_en);
    int acc;
    int cyc;
    logic [NUM_CH-1:0] v;
    logic [NUM_CH-1:0] l;
    logic rdy;
    logic taken;
    acc = 0;
    cyc = 0;
    while (acc < nbeats && cyc < 400) begin
      v = rnd ? NUM_CH'($urandom) : src_tvalid;
      if (!rnd) v[g] = 1'b1;
      l = NUM_CH'($urandom);
      l[g] = (acc == nbeats - 1);
      if (cyc < stalls) rdy = 1'b0;
      else rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (drop_en && cyc == 0) sched_en = 1'b0;
      src_tvalid = v;
      src_tlast  = l;
      dst_tready = rdy;
      taken = v[g] & rdy;
      step();
      if (taken) acc++;
      if (taken && acc == nbeats) begin
        check("done_sel", bus_sel, 0);
        check("done_pulse", pkt_done, 1);
        check("done_busy", busy, 0);
      end else begin
        check("lock_sel", bus_sel, 128 + g);
        check("lock_pulse", pkt_done, 0);
        check("lock_busy", busy, 1);
      end
      cyc++;
    end
    check("stream_beats", acc, nbeats);
    m_rr = (g + 1) % NUM_CH;
    dst_tready = 1'b0;
    src_tlast  = '0;
  endtask

  initial begin
    int g;
    logic [NUM_CH-1:0] mask;
    n_cmp      = 0;
    n_err      = 0;
    m_rr       = 0;
    rst_n      = 1'b0;
    sched_en   = 1'b0;
    src_tvalid = '0;
    src_tlast  = '0;
    dst_tready = 1'b0;

    #1;
    check("rst_sel", bus_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_sel", bus_sel, 0);

    // Single request on ch2, three-beat packet.
    request(14'h0004, g);
    check("ch2_grant", bus_sel, 130);
    stream(g, 3, 0, 1'b0, 1'b0);
    src_tvalid = '0;
    step();
    check("after_pkt_pulse", pkt_done, 0);

    // Reset clears the round-robin pointer: full request set grants 0..13, 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rr  = 0;
    for (int i = 0; i < NUM_CH + 1; i++) begin
      request(14'h3FFF, g);
      stream(g, 1, 0, 1'b0, 1'b0);
    end

    // Grant lock on ch5 through 20 stalled cycles with other channels toggling.
    src_tvalid = '0;
    step();
    request(14'h0020, g);
    stream(g, 1, 20, 1'b1, 1'b0);

    // sched_en drops during a ch2 packet: packet completes, no new grant.
    src_tvalid = '0;
    step();
    request(14'h0004, g);
    stream(g, 3, 0, 1'b0, 1'b1);
    src_tvalid = 14'h3FFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("en_low_busy", busy, 0);
      check("en_low_sel", bus_sel, 0);
    end
    request(14'h3FFF, g);
    stream(g, 1, 0, 1'b0, 1'b0);

`ifdef SCHED_WATCHDOG_EN
    // ch7 streams MAX_BEATS beats with no tlast: forced exit, sticky error.
    src_tvalid = '0;
    step();
    check("wdog_clear", wdog_err, 0);
    request(14'h0080, g);
    for (int b = 1; b <= MAX_BEATS; b++) begin
      src_tvalid = 14'h0080;
      src_tlast  = '0;
      dst_tready = 1'b1;
      step();
      if (b < MAX_BEATS) begin
        check("wdog_hold_sel", bus_sel, 128 + g);
      end else begin
        check("wdog_exit_sel", bus_sel, 0);
        check("wdog_no_pulse", pkt_done, 0);
        check("wdog_flag", wdog_err, 1);
      end
    end
    m_rr = (g + 1) % NUM_CH;
    dst_tready = 1'b0;
    request(14'h3FFF, g);
    stream(g, 1, 0, 1'b0, 1'b0);
    check("wdog_sticky", wdog_err, 1);
`endif

    // Asynchronous reset in the middle of a ch9 transfer.
    src_tvalid = '0;
    step();
    request(14'h0200, g);
    dst_tready = 1'b0;
    step();
    check("pre_rst_sel", bus_sel, 128 + g);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", bus_sel, 0);
    check("async_rst_busy", busy, 0);
`ifdef SCHED_WATCHDOG_EN
    check("async_rst_wdog", wdog_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_rr  = 0;
    request(14'h3FFF, g);
    check("post_rst_grant", bus_sel, 128);
    stream(g, 2, 0, 1'b0, 1'b0);

    // Randomized packets against the reference model.
    for (int p = 0; p < 25; p++) begin
      mask = NUM_CH'($urandom);
      if (mask == '0) mask[$urandom_range(0, NUM_CH - 1)] = 1'b1;
      request(mask, g);
      stream(g, $urandom_range(1, MAX_BEATS), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
